// File: rtl/pe_act_skew_feeder_if.sv
// Activation-vector input handshake for the PE row feeder.
//
// Signals:
//   in_valid  upstream has a vector on in_act/in_last
//   in_ready  feeder can take a vector this cycle
//   in_act    packed vector, element r at [(r+1)*data_width-1 : r*data_width]
//   in_last   marks the final vector of a stream (meaningful only on accept)
//
// Modports: master = upstream producer, slave = the feeder.
interface pe_act_skew_feeder_if #(
    parameter int unsigned data_width      = 19,
    parameter int unsigned w_tile_row_size = 6
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [data_width*w_tile_row_size-1:0] in_act;
    logic                                  in_last;

    modport master (
        output in_valid,
        output in_act,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_act,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/pe_act_skew_feeder.sv
// Upstream feeder for the PE row array.
//
// Takes one activation vector per accepted handshake and presents element r to PE row r
// r cycles later than row 0 (diagonal skew), so the array sees a wavefront. After the
// last vector of a stream it runs a fixed drain phase long enough for the final partial
// sums to traverse every row and column, then pulses done for one cycle.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous reset, active HIGH (1 = reset)
//   in_bus           slave side of the vector handshake (valid/ready/act/last)
//   active_left_out  slice r drives active_left of PE row r
//   w_compute        compute enable for all PE rows (high in FEED and DRAIN)
//   busy             stream in progress (same timing as w_compute)
//   done             one-cycle pulse in the first IDLE cycle after DRAIN
//   vec_count        vectors accepted in the current/last stream, saturating
module pe_act_skew_feeder #(
    parameter int unsigned data_width         = 19,
    parameter int unsigned w_tile_row_size    = 6,
    parameter int unsigned w_tile_column_size = 6,
    parameter int unsigned cnt_width          = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    pe_act_skew_feeder_if.slave                   in_bus,
    output logic [data_width*w_tile_row_size-1:0] active_left_out,
    output logic                                  w_compute,
    output logic                                  busy,
    output logic                                  done,
    output logic [cnt_width-1:0]                  vec_count
);

    // Drain covers the skew of the last row plus propagation across all columns.
    localparam int unsigned drain_len       = (w_tile_row_size - 1) + w_tile_column_size;
    localparam int unsigned drain_cnt_width = (drain_len > 1) ? $clog2(drain_len) : 1;
    localparam logic [drain_cnt_width-1:0] drain_init = drain_cnt_width'(drain_len - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain
    } state_e;

    state_e                     state_q;
    logic [drain_cnt_width-1:0] drain_cnt_q;
    logic                       busy_q;
    logic                       done_q;
    logic [cnt_width-1:0]       vec_count_q;
    logic                       accept;

    // Ready depends only on the state register, never on in_valid.
    assign in_bus.in_ready = (state_q != StDrain);
    assign accept          = in_bus.in_valid && in_bus.in_ready;

    // Control FSM: state, drain down-counter, busy, done pulse and vector counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        busy_q      <= 1'b1;
                        vec_count_q <= cnt_width'(1);
                        if (in_bus.in_last) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= drain_init;
                        end else begin
                            state_q <= StFeed;
                        end
                    end
                end
                StFeed: begin
                    if (accept) begin
                        if (vec_count_q != '1) begin
                            vec_count_q <= vec_count_q + 1'b1;
                        end
                        if (in_bus.in_last) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= drain_init;
                        end
                    end
                end
                StDrain: begin
                    // Counter is loaded with drain_len-1 so DRAIN spans exactly drain_len cycles.
                    if (drain_cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign w_compute = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;

    // Skew delay lines: row r has r+1 stages. Non-accept cycles inject zero, and the
    // lines shift every cycle regardless of state, so bubbles travel with the data.
    for (genvar r = 0; r < w_tile_row_size; r++) begin : g_row
        logic [data_width-1:0] line_q [r+1];

        always_ff @(posedge clk) begin
            if (rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    line_q[s] <= '0;
                end
            end else begin
                line_q[0] <= accept ? in_bus.in_act[r*data_width +: data_width] : '0;
                for (int s = 1; s <= r; s++) begin
                    line_q[s] <= line_q[s-1];
                end
            end
        end

        assign active_left_out[r*data_width +: data_width] = line_q[r];
    end

endmodule
